// File: rtl/seven_seg_scan_pkg.sv
// Shared seven-segment definitions for the display blocks.
//   SEG_DIGIT   active-low {g,f,e,d,c,b,a} patterns for decimal 0..9
//   SEG_DASH    shown for any digit value outside its legal range
//   SEG_BLANK   all segments off
//   digit_idx_t index of a digit position on the 4-digit display
//   digit_in_range() range check used by the decoders
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = 2;

    typedef logic [IDX_W-1:0] digit_idx_t;

    // Digit positions, rightmost first.
    typedef enum logic [IDX_W-1:0] {
        DIG_SEC_ONES = 2'd0,
        DIG_SEC_TENS = 2'd1,
        DIG_MIN_ONES = 2'd2,
        DIG_MIN_TENS = 2'd3
    } digit_pos_e;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic digit_in_range(input logic [3:0] value,
                                            input logic [3:0] max_digit);
        return value <= max_digit;
    endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Digit interface between the stopwatch counter and the display scanner.
//   dig0..dig3  BCD time digits (sec ones, sec tens, min ones, min tens)
//   adj_en      adjust mode active, enables blinking
//   adj_sel     0: seconds pair blinks, 1: minutes pair blinks
//   seg         active-low cathodes {dp,g,f,e,d,c,b,a}
//   an          active-low anodes, an[0] is the rightmost digit
// master: counter side (drives digits), slave: scanner side (drives pins).
interface seven_seg_scan_if;

    logic [3:0] dig0;
    logic [2:0] dig1;
    logic [3:0] dig2;
    logic [2:0] dig3;
    logic       adj_en;
    logic       adj_sel;
    logic [7:0] seg;
    logic [3:0] an;

    modport master (
        output dig0, dig1, dig2, dig3, adj_en, adj_sel,
        input  seg, an
    );

    modport slave (
        input  dig0, dig1, dig2, dig3, adj_en, adj_sel,
        output seg, an
    );

endinterface

// File: rtl/seven_seg_scan_bcd_to_seg.sv
// Combinational BCD to seven-segment decoder.
//   value      4-bit digit value
//   max_digit  largest legal value for this digit position (9 or 5)
//   pattern    active-low {g,f,e,d,c,b,a}; dash when value exceeds max_digit
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] value,
    input  logic [3:0] max_digit,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        if (digit_in_range(value, max_digit)) begin
            pattern = SEG_DIGIT[value];
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode seven-segment scanner for the stopwatch.
// Time-multiplexes the anodes over four equal slots, shows a frame-stable
// snapshot of the digits, blanks the anodes at the start of every slot to
// stop ghosting, blinks the selected digit pair in adjust mode and lights
// the decimal point of the minutes-ones digit as the mm.ss separator.
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   seven_seg_scan_if.slave (digits/adjust in, seg/an out)
module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 500,
    parameter int BLANK_CYC   = 1000,
    parameter int BLINK_HZ    = 2,
    parameter int LZ_SUPPRESS = 0
) (
    input  logic            clk,
    input  logic            rst,
    seven_seg_scan_if.slave bus
);

    localparam int DIV     = CLK_HZ / SCAN_HZ;
    localparam int HALF    = CLK_HZ / (2 * BLINK_HZ);
    localparam int SLOT_W  = (DIV  > 2) ? $clog2(DIV)  : 1;
    localparam int BLINK_W = (HALF > 2) ? $clog2(HALF) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIV - 1);
    localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYC);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(HALF - 1);

    logic [SLOT_W-1:0]               slot_cnt;
    digit_idx_t                      idx;
    logic [BLINK_W-1:0]              blink_cnt;
    logic                            phase;
    logic [NUM_DIGITS-1:0][3:0]      shadow;
    logic                            first_frame;
    logic [7:0]                      seg_q;
    logic [3:0]                      an_q;

    logic                            slot_end;
    logic                            capture;
    logic [3:0]                      cur_value;
    logic [3:0]                      cur_max;
    logic [6:0]                      cur_pattern;
    logic                            blank_slot;
    logic [3:0]                      an_next;
    logic [7:0]                      seg_next;

    assign slot_end = (slot_cnt == SLOT_LAST);

    // Snapshot at the 3->0 wrap so a frame never mixes old and new digits;
    // right after reset the first frame grabs the inputs immediately.
    assign capture = first_frame || (slot_end && (idx == DIG_MIN_TENS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            idx      <= idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Leaving adjust mode clears the phase so the next entry starts visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!bus.adj_en) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow      <= '0;
            first_frame <= 1'b1;
        end else begin
            first_frame <= 1'b0;
            if (capture) begin
                shadow <= {{1'b0, bus.dig3}, bus.dig2, {1'b0, bus.dig1}, bus.dig0};
            end
        end
    end

    // Tens digits (odd positions) only go to 5.
    assign cur_value = shadow[idx];
    assign cur_max   = idx[0] ? 4'd5 : 4'd9;

    bcd_to_seg u_dec (
        .value     (cur_value),
        .max_digit (cur_max),
        .pattern   (cur_pattern)
    );

    // idx[1] separates the seconds pair (0) from the minutes pair (1).
    always_comb begin
        blank_slot = bus.adj_en && phase && (idx[1] == bus.adj_sel);
        if ((LZ_SUPPRESS != 0) && (idx == DIG_MIN_TENS) && (shadow[3] == 4'd0)) begin
            blank_slot = 1'b1;
        end
    end

    always_comb begin
        an_next = 4'hF;
        if (!(slot_cnt < BLANK_END) && !blank_slot) begin
            an_next = ~(4'b0001 << idx);
        end
        seg_next = {(idx != DIG_MIN_ONES), cur_pattern};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= 4'hF;
            seg_q <= 8'hFF;
        end else begin
            an_q  <= an_next;
            seg_q <= seg_next;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;

endmodule
